udp_line_scheduler: RTL and testbench
=====================================

Name: udp_line_scheduler

Overview:
- Sequences per-line UDP transmission of both camera streams in the rgmii_clk domain.
- Replaces the free-running send-trigger generator.
- Round-robins between cam1 and cam2 lines that are ready in the line swap buffer, and fires a combined trigger to the line buffer and the UDP packet engine.
- Tracks per-camera row indices, enforces a minimum inter-packet gap, and detects stalled transfers.

Parameters:
- V_ACT, 720, rows per frame; per-camera row counter wraps after V_ACT-1.
- GAP_CYCLES, 125000, minimum clk cycles between the end of one packet (done or timeout) and the next launch; must be >= 1.
- TIMEOUT_CYCLES, 65535, maximum clk cycles from launch to tx_done before the transfer is abandoned.

Ports:
- clk  input  1  rgmii_clk domain clock.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  send switch, synchronised upstream; level.
- connected  input  1  link/ARP-resolved status from the UDP engine; level.
- line_avail  input  2  bit0 = cam1 line ready, bit1 = cam2 line ready; level.
- tx_done  input  1  one-cycle pulse at the end of UDP frame transmission.
- resync  input  1  one-cycle pulse at frame start; clears row counters.
- trig  output  1  one-cycle launch pulse driving both line buffer trig and UDP trig.
- cam_id  output  1  0 = cam1, 1 = cam2; valid and stable from trig until the packet completes.
- cam_row  output  10  row index of the launched line; stable with cam_id.
- busy  output  1  high from trig until tx_done or timeout.
- frame_done  output  1  one-cycle pulse when a camera's row counter wraps.
- timeout_err  output  1  sticky; cleared only by rst.
- sent_count  output  16  count of completed packets, wraps at 65535->0.

Behaviour:
- Reset values: trig=0, cam_id=0, cam_row=0, busy=0, frame_done=0, timeout_err=0, sent_count=0. Row counters are 0, the round-robin pointer points to cam1, and the FSM is in IDLE.
- IDLE: when enable && connected, go to GAP and load the gap counter with GAP_CYCLES-1.
- GAP: decrement each cycle; at 0 go to SELECT.
- SELECT: apply the round-robin grant over line_avail, starting from the pointer.
  - If only one bit is set, grant that camera.
  - If none are set, hold in SELECT.
  - On grant, latch cam_id and cam_row (that camera's row counter) and go to LAUNCH.
- LAUNCH: trig=1 for exactly this cycle; busy rises in the same cycle; load the timeout counter; go to WAIT.
- WAIT, on tx_done:
  - Increment the granted camera's row counter. When incrementing from V_ACT-1 it wraps to 0 and frame_done pulses on the next cycle.
  - Increment sent_count.
  - Point the round-robin pointer to the other camera.
  - Drop busy and go to GAP.
- WAIT, timeout counter reaching 0 without tx_done:
  - Set timeout_err; drop busy.
  - Leave the row counter unchanged, so the same line is retried.
  - Still advance the pointer, so the other camera is not starved.
  - Go to GAP.
- tx_done and timeout on the same cycle: treat as done, and do not set timeout_err.
- tx_done outside WAIT is ignored.
- Launch latency: the minimum from entering SELECT with line_avail set to the trig pulse is 1 cycle. From tx_done to the next trig is GAP_CYCLES+2 cycles if a line is available.
- enable deasserted:
  - In GAP or SELECT, go to IDLE next cycle.
  - In LAUNCH or WAIT, finish the packet normally, then go to IDLE instead of GAP.
- connected deasserted: handled like enable deassert, except that in WAIT the transfer is abandoned immediately. Go to IDLE with busy=0, no row advance, and no timeout_err.
- resync:
  - In IDLE, GAP or SELECT, clear both row counters and set the pointer to cam1 next cycle.
  - In LAUNCH or WAIT, defer resync as a pending flag and apply it at packet completion; this overrides that completion's row increment and pointer update.
  - Multiple resyncs while pending collapse into one.
- rst mid-transfer: all state returns to reset values immediately. A tx_done arriving later lands in IDLE and is ignored.
- cam_id and cam_row are held at their last launched values when not busy.

Test Plan:
- Basic: GAP_CYCLES=4, enable=connected=1, line_avail=2'b11, tx_done 10 cycles after each trig → trig alternates cam_id 0,1,0,1; rows go 0,0,1,1; sent_count=4 after four done pulses.
- Single requester: line_avail=2'b01 only → every grant is cam1 and cam_row increments 0..5. Raise bit1 while a cam1 packet is in flight → the next grant goes to cam2.
- Wrap: V_ACT=4, cam1 only → rows 0,1,2,3,0; frame_done pulses once, one cycle after the 4th tx_done.
- Timeout: TIMEOUT_CYCLES=20, no tx_done → timeout_err=1 and busy=0 at launch+21. With line_avail=2'b01, the next trig is cam1 with the same row.
- Disable/link loss: drop enable during WAIT → the packet completes, then no further trig. Drop connected during WAIT → busy=0 next cycle, no sent_count increment, and the row is unchanged.
- Resync: pulse resync during WAIT with rows at cam1=5, cam2=5 → after tx_done both rows are 0 and the next grant is cam1, row 0.

Source files
------------

// File: rtl/udp_line_scheduler.sv
// udp_line_scheduler
// Sequences per-line UDP transmission for two camera streams in the rgmii_clk
// domain. Round-robins between ready cam1/cam2 lines, fires one combined
// launch pulse, tracks per-camera row indices, enforces an inter-packet gap
// and abandons transfers that never report completion.
//
// Handshake: line_avail is a level "line ready" per camera. A grant is taken
// only in SELECT and is announced by a one-cycle trig with cam_id/cam_row
// already valid. The packet is owned (busy=1) until tx_done, timeout or link
// loss; tx_done is only honoured while a packet is owned.
module udp_line_scheduler #(
    parameter int V_ACT          = 720,
    parameter int GAP_CYCLES     = 125000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        connected,
    input  logic [1:0]  line_avail,
    input  logic        tx_done,
    input  logic        resync,
    output logic        trig,
    output logic        cam_id,
    output logic [9:0]  cam_row,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [15:0] sent_count
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]    ROW_LAST = 10'(V_ACT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GAP    = 3'd1;
    localparam logic [2:0] S_SELECT = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;
    logic [9:0]    row0_q, row0_d;
    logic [9:0]    row1_q, row1_d;
    logic          ptr_q, ptr_d;
    logic          pend_q, pend_d;
    logic          cam_id_q, cam_id_d;
    logic [9:0]    cam_row_q, cam_row_d;
    logic          trig_q, trig_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          terr_q, terr_d;
    logic [15:0]   sent_q, sent_d;

    logic          run;
    logic          clr_rows;
    logic          grant_cam;

    assign run = enable && connected;

    // Next-state logic: FSM, arbitration, row tracking and completion handling.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        to_d         = to_q;
        row0_d       = row0_q;
        row1_d       = row1_q;
        ptr_d        = ptr_q;
        pend_d       = pend_q;
        cam_id_d     = cam_id_q;
        cam_row_d    = cam_row_q;
        trig_d       = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        terr_d       = terr_q;
        sent_d       = sent_q;
        clr_rows     = 1'b0;
        grant_cam    = 1'b0;

        case (state_q)
            S_IDLE: begin
                clr_rows = resync;
                if (run) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end
            end

            S_GAP: begin
                clr_rows = resync;
                if (!run) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    state_d = S_SELECT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            S_SELECT: begin
                clr_rows = resync;
                if (!run) begin
                    state_d = S_IDLE;
                end else if (line_avail != 2'b00) begin
                    // A resync in this cycle makes the grant see the cleared
                    // pointer and rows so the launched line matches the new frame.
                    if (line_avail == 2'b11) begin
                        grant_cam = resync ? 1'b0 : ptr_q;
                    end else begin
                        grant_cam = line_avail[1];
                    end
                    cam_id_d = grant_cam;
                    if (resync) begin
                        cam_row_d = '0;
                    end else begin
                        cam_row_d = grant_cam ? row1_q : row0_q;
                    end
                    trig_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                pend_d  = pend_q | resync;
                to_d    = TO_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (tx_done) begin
                    // Completion wins over a coincident timeout or link loss.
                    busy_d  = 1'b0;
                    sent_d  = sent_q + 16'd1;
                    gap_d   = GAP_LOAD;
                    state_d = run ? S_GAP : S_IDLE;
                    if (pend_q || resync) begin
                        clr_rows = 1'b1;
                    end else begin
                        ptr_d = ~cam_id_q;
                        if (cam_id_q) begin
                            if (row1_q == ROW_LAST) begin
                                row1_d       = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                row1_d = row1_q + 10'd1;
                            end
                        end else begin
                            if (row0_q == ROW_LAST) begin
                                row0_d       = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                row0_d = row0_q + 10'd1;
                            end
                        end
                    end
                end else if (!connected) begin
                    // Link lost: drop the packet silently; row and pointer stay.
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                    clr_rows = pend_q || resync;
                end else if (to_q == '0) begin
                    // Stalled: keep the row so the same line is retried, but
                    // move the pointer so the other camera still gets a turn.
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = run ? S_GAP : S_IDLE;
                    if (pend_q || resync) begin
                        clr_rows = 1'b1;
                    end else begin
                        ptr_d = ~cam_id_q;
                    end
                end else begin
                    to_d   = to_q - 1'b1;
                    pend_d = pend_q | resync;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clr_rows) begin
            row0_d = '0;
            row1_d = '0;
            ptr_d  = 1'b0;
            pend_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_q        <= '0;
            to_q         <= '0;
            row0_q       <= '0;
            row1_q       <= '0;
            ptr_q        <= 1'b0;
            pend_q       <= 1'b0;
            cam_id_q     <= 1'b0;
            cam_row_q    <= '0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            terr_q       <= 1'b0;
            sent_q       <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            to_q         <= to_d;
            row0_q       <= row0_d;
            row1_q       <= row1_d;
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            cam_id_q     <= cam_id_d;
            cam_row_q    <= cam_row_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            terr_q       <= terr_d;
            sent_q       <= sent_d;
        end
    end

    assign trig        = trig_q;
    assign cam_id      = cam_id_q;
    assign cam_row     = cam_row_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = terr_q;
    assign sent_count  = sent_q;

endmodule

// File: tb/tb_udp_line_scheduler.sv
// Bench for udp_line_scheduler: two instances share one stimulus stream, a
// long-frame instance for row/arbitration checks and a 4-row instance for
// frame wrap checks. Packet vectors are table driven; disable, link loss,
// resync and reset cases are hand sequences.
module tb_udp_line_scheduler;

    localparam int GAP_C = 4;
    localparam int TO_C  = 20;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        connected;
    logic [1:0]  line_avail;
    logic        tx_done;
    logic        resync;

    logic        trig, cam_id, busy, frame_done, timeout_err;
    logic [9:0]  cam_row;
    logic [15:0] sent_count;

    logic        trig_w, cam_id_w, busy_w, frame_done_w, timeout_err_w;
    logic [9:0]  cam_row_w;
    logic [15:0] sent_count_w;

    int total;
    int bad;
    int trig_cnt;
    int fd_cnt;
    int fd_w_cnt;

    typedef struct packed {
        logic [1:0]  avail_next;
        logic [7:0]  done_after;
        logic        exp_id;
        logic [9:0]  exp_row;
        logic [9:0]  exp_row_w;
        logic [15:0] exp_sent;
        logic        exp_terr;
        logic        exp_fd_w;
        logic        chk_lat;
    } vec_t;

    vec_t vecs [11];

    udp_line_scheduler #(.V_ACT(720), .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TO_C)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .connected(connected),
        .line_avail(line_avail), .tx_done(tx_done), .resync(resync),
        .trig(trig), .cam_id(cam_id), .cam_row(cam_row), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err), .sent_count(sent_count)
    );

    udp_line_scheduler #(.V_ACT(4), .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TO_C)) u_dut_w (
        .clk(clk), .rst(rst), .enable(enable), .connected(connected),
        .line_avail(line_avail), .tx_done(tx_done), .resync(resync),
        .trig(trig_w), .cam_id(cam_id_w), .cam_row(cam_row_w), .busy(busy_w),
        .frame_done(frame_done_w), .timeout_err(timeout_err_w), .sent_count(sent_count_w)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event monitors, sampled on the inactive edge
    always @(negedge clk) begin
        if (trig === 1'b1) trig_cnt <= trig_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (frame_done_w === 1'b1) fd_w_cnt <= fd_w_cnt + 1;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_trig(input string name, output int n);
        n = 0;
        while (trig !== 1'b1 && n < 200) begin
            tick();
            n = n + 1;
        end
        chk({name, " trig seen"}, {31'd0, trig}, 32'd1);
    endtask

    task automatic pulse_done_after(input int k);
        repeat (k) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        int lat;
        int snap;
        string nm;

        total = 0; bad = 0;
        trig_cnt = 0; fd_cnt = 0; fd_w_cnt = 0;
        rst = 1'b1; enable = 1'b0; connected = 1'b0;
        line_avail = 2'b00; tx_done = 1'b0; resync = 1'b0;

        //            next   done  id    row     row_w   sent    terr  fd_w  lat
        vecs[0]  = '{2'b11, 8'd10, 1'b0, 10'd0, 10'd0, 16'd1,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 8'd10, 1'b1, 10'd0, 10'd0, 16'd2,  1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 8'd10, 1'b0, 10'd1, 10'd1, 16'd3,  1'b0, 1'b0, 1'b1};
        vecs[3]  = '{2'b01, 8'd10, 1'b1, 10'd1, 10'd1, 16'd4,  1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'b01, 8'd10, 1'b0, 10'd2, 10'd2, 16'd5,  1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'b01, 8'd10, 1'b0, 10'd3, 10'd3, 16'd6,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{2'b01, 8'd10, 1'b0, 10'd4, 10'd0, 16'd7,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b11, 8'd10, 1'b0, 10'd5, 10'd1, 16'd8,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'b01, 8'd10, 1'b1, 10'd2, 10'd2, 16'd9,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2'b01, 8'd0,  1'b0, 10'd6, 10'd2, 16'd9,  1'b1, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 8'd5,  1'b0, 10'd6, 10'd2, 16'd10, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst trig", {31'd0, trig}, 32'd0);
        chk("rst cam_id", {31'd0, cam_id}, 32'd0);
        chk("rst cam_row", {22'd0, cam_row}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst sent_count", {16'd0, sent_count}, 32'd0);
        rst = 1'b0;
        tick();
        enable = 1'b1; connected = 1'b1; line_avail = 2'b11;

        // Table-driven packets: basic alternation, single requester, wrap, timeout
        for (int i = 0; i < 11; i++) begin
            nm = $sformatf("v%0d", i);
            wait_trig(nm, lat);
            if (vecs[i].chk_lat) chk({nm, " latency"}, lat, GAP_C + 1);
            chk({nm, " cam_id"}, {31'd0, cam_id}, {31'd0, vecs[i].exp_id});
            chk({nm, " cam_row"}, {22'd0, cam_row}, {22'd0, vecs[i].exp_row});
            chk({nm, " cam_id_w"}, {31'd0, cam_id_w}, {31'd0, vecs[i].exp_id});
            chk({nm, " cam_row_w"}, {22'd0, cam_row_w}, {22'd0, vecs[i].exp_row_w});
            chk({nm, " busy at trig"}, {31'd0, busy}, 32'd1);
            line_avail = vecs[i].avail_next;
            if (vecs[i].done_after != 8'd0) begin
                pulse_done_after(int'(vecs[i].done_after));
                chk({nm, " frame_done_w"}, {31'd0, frame_done_w}, {31'd0, vecs[i].exp_fd_w});
                chk({nm, " frame_done"}, {31'd0, frame_done}, 32'd0);
            end else begin
                repeat (TO_C) tick();
                chk({nm, " busy before timeout"}, {31'd0, busy}, 32'd1);
                chk({nm, " terr before timeout"}, {31'd0, timeout_err}, 32'd0);
                tick();
            end
            chk({nm, " busy after"}, {31'd0, busy}, 32'd0);
            chk({nm, " sent_count"}, {16'd0, sent_count}, {16'd0, vecs[i].exp_sent});
            chk({nm, " timeout_err"}, {31'd0, timeout_err}, {31'd0, vecs[i].exp_terr});
        end
        tick();
        chk("frame_done_w pulses", fd_w_cnt, 1);
        chk("frame_done pulses", fd_cnt, 0);

        // Disable during WAIT: packet completes, then no further launch
        wait_trig("dis", lat);
        chk("dis cam_id", {31'd0, cam_id}, 32'd1);
        chk("dis cam_row", {22'd0, cam_row}, 32'd3);
        repeat (3) tick();
        enable = 1'b0;
        pulse_done_after(2);
        chk("dis busy", {31'd0, busy}, 32'd0);
        chk("dis sent", {16'd0, sent_count}, 32'd11);
        snap = trig_cnt;
        repeat (30) tick();
        chk("dis no trig", trig_cnt, snap);
        enable = 1'b1;

        // Link loss during WAIT: abandoned next cycle, row kept
        wait_trig("lnk", lat);
        chk("lnk cam_id", {31'd0, cam_id}, 32'd0);
        chk("lnk cam_row", {22'd0, cam_row}, 32'd7);
        repeat (3) tick();
        connected = 1'b0;
        tick();
        chk("lnk busy", {31'd0, busy}, 32'd0);
        chk("lnk sent", {16'd0, sent_count}, 32'd11);
        snap = trig_cnt;
        repeat (20) tick();
        chk("lnk no trig", trig_cnt, snap);
        connected = 1'b1;
        wait_trig("lnk retry", lat);
        chk("lnk retry cam_id", {31'd0, cam_id}, 32'd0);
        chk("lnk retry cam_row", {22'd0, cam_row}, 32'd7);
        pulse_done_after(4);
        chk("lnk retry sent", {16'd0, sent_count}, 32'd12);

        // Resync while idle, then build both rows up to 5
        enable = 1'b0;
        repeat (2) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nm = $sformatf("rs%0d", i);
            wait_trig(nm, lat);
            chk({nm, " cam_id"}, {31'd0, cam_id}, i % 2);
            chk({nm, " cam_row"}, {22'd0, cam_row}, i / 2);
            pulse_done_after(3);
        end
        chk("rs sent", {16'd0, sent_count}, 32'd22);

        // Resync during WAIT overrides the completion's increment and pointer
        wait_trig("rsw", lat);
        chk("rsw cam_id", {31'd0, cam_id}, 32'd0);
        chk("rsw cam_row", {22'd0, cam_row}, 32'd5);
        repeat (2) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        pulse_done_after(2);
        chk("rsw sent", {16'd0, sent_count}, 32'd23);
        wait_trig("rsw next", lat);
        chk("rsw next cam_id", {31'd0, cam_id}, 32'd0);
        chk("rsw next cam_row", {22'd0, cam_row}, 32'd0);
        pulse_done_after(3);
        wait_trig("rsw next2", lat);
        chk("rsw next2 cam_id", {31'd0, cam_id}, 32'd1);
        chk("rsw next2 cam_row", {22'd0, cam_row}, 32'd0);

        // Reset mid-transfer, late tx_done is ignored
        repeat (3) tick();
        enable = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst sent", {16'd0, sent_count}, 32'd0);
        tick();
        chk("arst timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("arst cam_id", {31'd0, cam_id}, 32'd0);
        chk("arst trig", {31'd0, trig}, 32'd0);
        rst = 1'b0;
        pulse_done_after(3);
        tick();
        chk("late done sent", {16'd0, sent_count}, 32'd0);
        chk("late done busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
